ro_trng_ctrl: RTL

//  Controller for a LUT-built ring-oscillator entropy source: gates the oscillator and

---
 rtl/ro_trng_pkg.sv | 17 +
 rtl/ro_trng_ctrl_sync.sv | 25 ++
 rtl/ro_trng_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ro_trng_pkg.sv
// Shared types and helpers for the ring-oscillator TRNG controller.
package ro_trng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_COLLECT = 3'd2,
        ST_HOLD    = 3'd3,
        ST_FAIL    = 3'd4
    } state_t;

    // Bits needed for a counter that must hold values 0..max_val.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ro_trng_ctrl_sync.sv
// Reusable two-flop synchroniser for a single asynchronous bit.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/ro_trng_ctrl.sv
// Ring-oscillator TRNG controller: oscillator gating, sampling, von Neumann
// correction, repetition-count health test and word packing onto a stream port.
module ro_trng_ctrl
    import ro_trng_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned SAMPLE_DIV = 16,
    parameter int unsigned WARMUP     = 256,
    parameter int unsigned RCT_LIMIT  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ro_in,
    output logic             ro_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             health_fail
);

    localparam int unsigned WARM_W = cnt_w(WARMUP);
    localparam int unsigned DIV_W  = cnt_w(SAMPLE_DIV);
    localparam int unsigned BIT_W  = cnt_w(WIDTH);
    localparam int unsigned REP_W  = cnt_w(RCT_LIMIT);

    state_t             r_state;
    state_t             w_next_state;

    logic               w_ro_sync;
    logic [WARM_W-1:0]  r_warm_cnt;
    logic [DIV_W-1:0]   r_div_cnt;
    logic               r_pair_flag;
    logic               r_first_bit;
    logic               r_prev_sample;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [REP_W-1:0]   r_rep_cnt;
    logic [WIDTH-1:0]   r_word;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_valid;
    logic               r_ro_en;
    logic               r_health_fail;

    logic               w_warm_done;
    logic               w_strobe;
    logic               w_emit;
    logic               w_word_done;
    logic [REP_W-1:0]   w_rep_next;
    logic               w_rct_trip;
    logic               w_xfer;
    logic [WIDTH-1:0]   w_word_next;

    sync_2ff u_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (ro_in),
        .o_q   (w_ro_sync)
    );

    assign w_warm_done = (r_state == ST_WARMUP)  && (r_warm_cnt == WARM_W'(WARMUP - 1));
    assign w_strobe    = (r_state == ST_COLLECT) && (r_div_cnt == DIV_W'(SAMPLE_DIV - 1));
    // A pair emits its first sample only when the two samples differ.
    assign w_emit      = w_strobe && r_pair_flag && (r_first_bit != w_ro_sync);
    assign w_word_done = w_emit && (r_bit_cnt == BIT_W'(WIDTH - 1));
    assign w_rct_trip  = w_strobe && (w_rep_next == REP_W'(RCT_LIMIT));
    assign w_xfer      = (r_state == ST_HOLD) && r_out_valid && out_ready;

    // Repetition count for the current strobe; a zero count means no previous sample yet.
    always_comb begin
        w_rep_next = REP_W'(1);
        if ((r_rep_cnt != '0) && (w_ro_sync == r_prev_sample)) begin
            if (r_rep_cnt == REP_W'(RCT_LIMIT)) begin
                w_rep_next = r_rep_cnt;
            end else begin
                w_rep_next = r_rep_cnt + REP_W'(1);
            end
        end
    end

    // Word with the emitted bit placed at the current bit index.
    always_comb begin
        w_word_next = r_word;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (r_bit_cnt == BIT_W'(i)) begin
                w_word_next[i] = r_first_bit;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; dropping en wins over every other transition.
    always_comb begin
        w_next_state = r_state;
        if (!en) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    w_next_state = ST_WARMUP;
                ST_WARMUP:  if (w_warm_done) w_next_state = ST_COLLECT;
                ST_COLLECT: begin
                    if (w_rct_trip) begin
                        w_next_state = ST_FAIL;
                    end else if (w_word_done) begin
                        w_next_state = ST_HOLD;
                    end
                end
                ST_HOLD:    if (w_xfer) w_next_state = ST_COLLECT;
                ST_FAIL:    w_next_state = ST_FAIL;
                default:    w_next_state = ST_IDLE;
            endcase
        end
    end

    // Counters, corrector, health state, packer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_warm_cnt    <= '0;
            r_div_cnt     <= '0;
            r_pair_flag   <= 1'b0;
            r_first_bit   <= 1'b0;
            r_prev_sample <= 1'b0;
            r_bit_cnt     <= '0;
            r_rep_cnt     <= '0;
            r_word        <= '0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_ro_en       <= 1'b0;
            r_health_fail <= 1'b0;
        end else begin
            r_ro_en       <= (w_next_state == ST_WARMUP) || (w_next_state == ST_COLLECT) ||
                             (w_next_state == ST_HOLD);
            r_health_fail <= (w_next_state == ST_FAIL);

            if ((w_next_state == ST_IDLE) || (w_next_state == ST_FAIL)) begin
                // Abort or health trip: everything in flight is discarded.
                r_warm_cnt    <= '0;
                r_div_cnt     <= '0;
                r_pair_flag   <= 1'b0;
                r_first_bit   <= 1'b0;
                r_prev_sample <= 1'b0;
                r_bit_cnt     <= '0;
                r_rep_cnt     <= '0;
                r_word        <= '0;
                r_out_data    <= '0;
                r_out_valid   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_warm_cnt <= '0;
                    end
                    ST_WARMUP: begin
                        if (w_warm_done) begin
                            r_warm_cnt  <= '0;
                            r_div_cnt   <= '0;
                            r_pair_flag <= 1'b0;
                            r_bit_cnt   <= '0;
                            r_rep_cnt   <= '0;
                            r_word      <= '0;
                        end else begin
                            r_warm_cnt <= r_warm_cnt + WARM_W'(1);
                        end
                    end
                    ST_COLLECT: begin
                        if (w_strobe) begin
                            r_div_cnt     <= '0;
                            r_pair_flag   <= ~r_pair_flag;
                            r_prev_sample <= w_ro_sync;
                            r_rep_cnt     <= w_rep_next;
                            if (!r_pair_flag) begin
                                r_first_bit <= w_ro_sync;
                            end
                            if (w_emit) begin
                                r_word    <= w_word_next;
                                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            end
                            if (w_word_done) begin
                                r_out_data  <= w_word_next;
                                r_out_valid <= 1'b1;
                            end
                        end else begin
                            r_div_cnt <= r_div_cnt + DIV_W'(1);
                        end
                    end
                    ST_HOLD: begin
                        // Repetition history survives the hand-off; the pairing restarts.
                        if (w_xfer) begin
                            r_out_valid <= 1'b0;
                            r_div_cnt   <= '0;
                            r_pair_flag <= 1'b0;
                            r_bit_cnt   <= '0;
                            r_word      <= '0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign ro_en       = r_ro_en;
    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign health_fail = r_health_fail;

endmodule
